// File: rtl/neokeon_rotr32_by1_fun_pkg.sv
// Shared Neokeon word types and bit-permutation helpers.
// Reused by Theta and Pi1/Pi2 blocks.
package neokeon_rotr32_by1_fun_pkg;

  localparam int NEOKEON_WORD_W = 32;

  typedef logic [NEOKEON_WORD_W-1:0] word_t;

  // Right rotate by one: bit 0 wraps into bit 31.
  function automatic word_t rotr1(input word_t w);
    word_t r;
    r = '0;
    for (int i = 0; i < NEOKEON_WORD_W; i++) begin
      r[i] = w[(i + 1) % NEOKEON_WORD_W];
    end
    return r;
  endfunction

endpackage

// File: rtl/neokeon_rotr_core.sv
// Combinational ROTR-by-1 permutation of one Neokeon word.
// Pure wiring, no arithmetic.
module neokeon_rotr_core
  import neokeon_rotr32_by1_fun_pkg::*;
(
  input  word_t data_i,
  output word_t data_o
);

  assign data_o = rotr1(data_i);

endmodule

// File: rtl/neokeon_rotr32_by1_fun.sv
// Registered ROTR32-by-1 with one-cycle latency.
// Output data holds between valid words.
module neokeon_rotr32_by1_fun
  import neokeon_rotr32_by1_fun_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ROT_AMT = 1
) (
  input  logic              inClk,
  input  logic              inRst,
  input  logic              inValid,
  input  logic [DATA_W-1:0] inDataWord,
  output logic [DATA_W-1:0] outputData,
  output logic              outValid
);

  if (DATA_W != NEOKEON_WORD_W || ROT_AMT != 1) begin : g_bad_cfg
    $error("neokeon_rotr32_by1_fun: only DATA_W=32, ROT_AMT=1");
  end

  word_t rot_w;
  word_t data_d, data_q;
  logic  valid_d, valid_q;

  neokeon_rotr_core u_core (
    .data_i (inDataWord),
    .data_o (rot_w)
  );

  // Word is only looked at when qualified, so idle X/Z never propagates.
  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    if (inValid) begin
      data_d  = rot_w;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge inClk) begin
    if (inRst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign outputData = data_q;
  assign outValid   = valid_q;

endmodule

// File: tb/tb_neokeon_rotr32_by1_fun.sv
// Directed and random checks for neokeon_rotr32_by1_fun.
// Expected values are hand-computed or an independent concat model.
module tb_neokeon_rotr32_by1_fun;

  logic        clk;
  logic        rst;
  logic        vld;
  logic [31:0] din;
  logic [31:0] dout;
  logic        vout;

  int tests;
  int fails;

  typedef struct {
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [7];

  neokeon_rotr32_by1_fun #(
    .DATA_W  (32),
    .ROT_AMT (1)
  ) dut (
    .inClk      (clk),
    .inRst      (rst),
    .inValid    (vld),
    .inDataWord (din),
    .outputData (dout),
    .outValid   (vout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic v,
                      input logic [31:0] d);
    rst = r;
    vld = v;
    din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] m;
    tests = 0;
    fails = 0;

    vecs[0] = '{32'h1111AAAA, 32'h0888D555};
    vecs[1] = '{32'h00000001, 32'h80000000};
    vecs[2] = '{32'h80000000, 32'h40000000};
    vecs[3] = '{32'hAAAAAAAA, 32'h55555555};
    vecs[4] = '{32'h00000000, 32'h00000000};
    vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[6] = '{32'h12345678, 32'h091A2B3C};

    rst = 1'b1;
    vld = 1'b1;
    din = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    step(1'b1, 1'b1, 32'hCAFEF00D);
    chk("rst_data", dout, 32'h0);
    chk("rst_valid", {31'b0, vout}, 32'h0);

    foreach (vecs[i]) begin
      step(1'b0, 1'b1, vecs[i].din);
      chk($sformatf("vec%0d_data", i), dout, vecs[i].exp);
      chk($sformatf("vec%0d_valid", i), {31'b0, vout}, 32'h1);
    end

    // Back-to-back stream then idle hold.
    step(1'b0, 1'b1, 32'h1);
    chk("b2b0_data", dout, 32'h80000000);
    chk("b2b0_valid", {31'b0, vout}, 32'h1);
    step(1'b0, 1'b1, 32'h2);
    chk("b2b1_data", dout, 32'h00000001);
    chk("b2b1_valid", {31'b0, vout}, 32'h1);
    step(1'b0, 1'b1, 32'h3);
    chk("b2b2_data", dout, 32'h80000001);
    chk("b2b2_valid", {31'b0, vout}, 32'h1);
    step(1'b0, 1'b0, 32'hDEADBEEF);
    chk("idle0_data", dout, 32'h80000001);
    chk("idle0_valid", {31'b0, vout}, 32'h0);
    step(1'b0, 1'b0, 32'hFFFFFFFF);
    chk("idle1_data", dout, 32'h80000001);
    chk("idle1_valid", {31'b0, vout}, 32'h0);

    // Reset mid-stream discards the concurrent word.
    step(1'b1, 1'b1, 32'h12345678);
    chk("midrst_data", dout, 32'h0);
    chk("midrst_valid", {31'b0, vout}, 32'h0);
    step(1'b0, 1'b1, 32'h00000003);
    chk("postrst_data", dout, 32'h80000001);
    chk("postrst_valid", {31'b0, vout}, 32'h1);

    for (int k = 0; k < 10000; k++) begin
      w = $urandom;
      m = {w[0], w[31:1]};
      step(1'b0, 1'b1, w);
      chk("rand_data", dout, m);
      if (vout !== 1'b1) begin
        chk("rand_valid", {31'b0, vout}, 32'h1);
      end
    end

    step(1'b0, 1'b0, 32'h0);
    chk("end_valid", {31'b0, vout}, 32'h0);
    chk("end_hold", dout, m);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
